// File: rtl/alu_pkg.sv
// Shared ALU types: sequencer state encoding and nibble slice width.
package alu_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : alu_pkg

// File: rtl/full_adder_4b.sv
// Nibble-wide ripple adder slice: {cout, sum} = a + b + cin.
module full_adder_4b
    import alu_pkg::*;
(
    input  logic                cin,
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    output logic                cout,
    output logic [NIBBLE_W-1:0] sum
);

    localparam int unsigned TOTAL_W = NIBBLE_W + 1;

    logic [TOTAL_W-1:0] total;

    // Widen operands by one bit so the carry-out falls out of the addition.
    always_comb begin
        total = TOTAL_W'(a) + TOTAL_W'(b) + TOTAL_W'(cin);
    end

    assign cout = total[TOTAL_W-1];
    assign sum  = total[NIBBLE_W-1:0];

endmodule : full_adder_4b

// File: rtl/adder_seq_ctrl.sv
// Wide add/subtract sequencer: one nibble per clock through a shared
// full_adder_4b slice, carry chained through a register, result held
// until downstream acknowledges it.
module adder_seq_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0]  i_a,
    input  logic [NIBBLE_W*NIBBLES-1:0]  i_b,
    input  logic                         i_cin,
    input  logic                         i_sub,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [NIBBLE_W*NIBBLES-1:0]  o_sum,
    output logic                         o_carry,
    output logic                         o_overflow
);

    localparam int unsigned WIDTH = NIBBLE_W * NIBBLES;
    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t state_q;
    state_t state_d;

    logic [IDX_W-1:0]                   idx_q;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]   a_q;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]   b_q;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]   sum_q;
    logic                               carry_q;
    logic                               cout_q;
    logic                               ovf_q;
    logic                               ready_q;
    logic                               valid_q;

    logic                               accept;
    logic                               last_nib;
    logic [NIBBLE_W-1:0]                nib_sum;
    logic                               nib_cout;

    // Next-state logic and per-cycle strobes.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        last_nib = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (idx_q == LAST_IDX) begin
                    last_nib = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; handshake flags are registered from the next state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == IDLE);
            valid_q <= (state_d == DONE);
        end
    end

    // Shared nibble slice, fed from the current nibble of each operand.
    full_adder_4b u_nibble_adder (
        .cin  (carry_q),
        .a    (a_q[idx_q]),
        .b    (b_q[idx_q]),
        .cout (nib_cout),
        .sum  (nib_sum)
    );

    // Operand capture at accept, then one result nibble per RUN cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= i_a;
            b_q     <= i_sub ? ~i_b : i_b;
            carry_q <= i_sub | i_cin;
            idx_q   <= '0;
        end else if (state_q == RUN) begin
            sum_q[idx_q] <= nib_sum;
            carry_q      <= nib_cout;
            if (last_nib) begin
                idx_q  <= '0;
                cout_q <= nib_cout;
                // Operands of equal sign producing a result of the other sign.
                ovf_q  <= (a_q[NIBBLES-1][NIBBLE_W-1] == b_q[NIBBLES-1][NIBBLE_W-1])
                       && (nib_sum[NIBBLE_W-1] != a_q[NIBBLES-1][NIBBLE_W-1]);
            end else begin
                idx_q <= idx_q + IDX_ONE;
            end
        end
    end

    assign o_ready    = ready_q;
    assign o_valid    = valid_q;
    assign o_sum      = WIDTH'(sum_q);
    assign o_carry    = cout_q;
    assign o_overflow = ovf_q;

endmodule : adder_seq_ctrl

// File: tb/tb_adder_seq_ctrl.sv
// Scoreboard bench for adder_seq_ctrl (NIBBLES=4 main instance, NIBBLES=1 corner instance).
module tb_adder_seq_ctrl;

    typedef struct {
        int unsigned sum;
        int unsigned carry;
        int unsigned ovf;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        int unsigned sum;
        int unsigned carry;
        int unsigned ovf;
    } dir_t;

    logic        clk = 1'b0;
    logic        rst;

    logic        i_valid, o_ready, i_cin, i_sub, o_valid, i_ready, o_carry, o_ovf;
    logic [15:0] i_a, i_b, o_sum;

    logic        v1_in, r1_out, cin1, sub1, v1_out, r1_in, c1_out, ovf1_out;
    logic [3:0]  a1, b1, sum1_out;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit rdy_auto = 1'b0;

    res_t exp_q[$];
    int   acc_edge;
    bit   lat_pending = 1'b0;
    bit   held_valid  = 1'b0;
    res_t held;

    adder_seq_ctrl #(.NIBBLES(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_a(i_a), .i_b(i_b), .i_cin(i_cin), .i_sub(i_sub),
        .o_valid(o_valid), .i_ready(i_ready), .o_sum(o_sum),
        .o_carry(o_carry), .o_overflow(o_ovf)
    );

    adder_seq_ctrl #(.NIBBLES(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_valid(v1_in), .o_ready(r1_out),
        .i_a(a1), .i_b(b1), .i_cin(cin1), .i_sub(sub1),
        .o_valid(v1_out), .i_ready(r1_in), .o_sum(sum1_out),
        .o_carry(c1_out), .o_overflow(ovf1_out)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Downstream acceptance: random unless the main sequence takes over.
    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_auto) i_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks = n_checks + 1;
        n_fail   = n_fail + 1;
        $display("FAIL %s: bound expired, got no event, expected one (cycle %0d)", name, cyc);
    endtask

    function automatic int sx(input int unsigned x, input int w);
        return (x >= (32'd1 << (w - 1))) ? int'(x) - (1 << w) : int'(x);
    endfunction

    // Reference: plain unsigned/signed integer arithmetic at width w.
    function automatic res_t model(input int unsigned a, input int unsigned b,
                                   input logic cin, input logic sub, input int w);
        res_t        r;
        int unsigned mask = (32'd1 << w) - 32'd1;
        int unsigned u;
        int          s;
        if (sub) begin
            r.sum   = (a - b) & mask;
            r.carry = (a >= b) ? 32'd1 : 32'd0;
            s       = sx(a, w) - sx(b, w);
        end else begin
            u       = a + b + 32'(cin);
            r.sum   = u & mask;
            r.carry = (u >> w) & 32'd1;
            s       = sx(a, w) + sx(b, w) + int'(cin);
        end
        r.ovf = (s > (1 << (w - 1)) - 1 || s < -(1 << (w - 1))) ? 32'd1 : 32'd0;
        return r;
    endfunction

    // Monitor: pushes expectations at accept, checks latency, hold stability and results.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            exp_q.delete();
            lat_pending = 1'b0;
            held_valid  = 1'b0;
        end else begin
            if (o_valid) begin
                check("ready_low_in_done", 32'(o_ready), 32'd0);
                if (lat_pending) begin
                    check("latency", 32'(cyc - acc_edge), 32'd4);
                    lat_pending = 1'b0;
                end
                if (held_valid) begin
                    check("hold_sum", 32'(o_sum), held.sum);
                    check("hold_carry", 32'(o_carry), held.carry);
                    check("hold_ovf", 32'(o_ovf), held.ovf);
                end
                held.sum   = 32'(o_sum);
                held.carry = 32'(o_carry);
                held.ovf   = 32'(o_ovf);
                held_valid = 1'b1;
                if (i_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("sb_unexpected_result");
                    end else begin
                        res_t e;
                        e = exp_q.pop_front();
                        check("sb_sum", 32'(o_sum), e.sum);
                        check("sb_carry", 32'(o_carry), e.carry);
                        check("sb_ovf", 32'(o_ovf), e.ovf);
                    end
                    held_valid = 1'b0;
                end
            end else begin
                held_valid = 1'b0;
            end
            if (i_valid && o_ready) begin
                exp_q.push_back(model(32'(i_a), 32'(i_b), i_cin, i_sub, 16));
                acc_edge    = cyc + 1;
                lat_pending = 1'b1;
            end
        end
    end

    // Present a request, hold it until accepted, then scramble the operand pins.
    task automatic send(input logic [15:0] a_v, input logic [15:0] b_v,
                        input logic cin_v, input logic sub_v);
        bit got = 1'b0;
        @(posedge clk);
        #1;
        i_a = a_v; i_b = b_v; i_cin = cin_v; i_sub = sub_v; i_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (o_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail_now("accept_timeout");
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_a = 16'($urandom); i_b = 16'($urandom);
        i_cin = 1'($urandom); i_sub = 1'($urandom);
    endtask

    task automatic wait_valid();
        bit got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (o_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail_now("valid_timeout");
    endtask

    task automatic wait_idle();
        bit got = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (o_ready && exp_q.size() == 0) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail_now("idle_timeout");
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    // One NIBBLES=1 transaction, checked against the same reference at width 4.
    task automatic send1(input logic [3:0] a_v, input logic [3:0] b_v,
                         input logic cin_v, input logic sub_v);
        res_t e;
        e = model(32'(a_v), 32'(b_v), cin_v, sub_v, 4);
        @(posedge clk);
        #1;
        a1 = a_v; b1 = b_v; cin1 = cin_v; sub1 = sub_v; v1_in = 1'b1;
        @(negedge clk);
        check("n1_ready_idle", 32'(r1_out), 32'd1);
        @(posedge clk);
        #1;
        v1_in = 1'b0;
        a1 = 4'($urandom); b1 = 4'($urandom);
        @(negedge clk);
        check("n1_not_valid_yet", 32'(v1_out), 32'd0);
        @(negedge clk);
        check("n1_valid", 32'(v1_out), 32'd1);
        check("n1_sum", 32'(sum1_out), e.sum);
        check("n1_carry", 32'(c1_out), e.carry);
        check("n1_ovf", 32'(ovf1_out), e.ovf);
        @(negedge clk);
    endtask

    dir_t dir_tab[5];

    initial begin
        dir_tab[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 32'h5555, 32'd0, 32'd0};
        dir_tab[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 32'h0000, 32'd1, 32'd0};
        dir_tab[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 32'h8000, 32'd0, 32'd1};
        dir_tab[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 32'hFFFE, 32'd0, 32'd0};
        dir_tab[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 32'h7FFF, 32'd1, 32'd1};

        rst = 1'b1;
        i_valid = 1'b0; i_a = '0; i_b = '0; i_cin = 1'b0; i_sub = 1'b0; i_ready = 1'b0;
        v1_in = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0; r1_in = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_sum", 32'(o_sum), 32'd0);
        check("rst_carry", 32'(o_carry), 32'd0);
        check("rst_ovf", 32'(o_ovf), 32'd0);
        check("rst_n1_ready", 32'(r1_out), 32'd1);
        check("rst_n1_valid", 32'(v1_out), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdy_auto = 1'b1;

        // Directed arithmetic cases with hand-derived results.
        foreach (dir_tab[i]) begin
            send(dir_tab[i].a, dir_tab[i].b, dir_tab[i].cin, dir_tab[i].sub);
            wait_valid();
            check("dir_sum", 32'(o_sum), dir_tab[i].sum);
            check("dir_carry", 32'(o_carry), dir_tab[i].carry);
            check("dir_ovf", 32'(o_ovf), dir_tab[i].ovf);
            wait_idle();
        end

        // Backpressure: result must hold for 5 cycles while operands toggle.
        rdy_auto = 1'b0;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        send(16'h1234, 16'h1111, 1'b0, 1'b0);
        wait_valid();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            i_a = 16'($urandom);
            @(negedge clk);
            check("bp_valid", 32'(o_valid), 32'd1);
            check("bp_ready", 32'(o_ready), 32'd0);
            check("bp_sum", 32'(o_sum), 32'h2345);
        end
        @(posedge clk);
        #1;
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        @(negedge clk);
        check("bp_back_idle", 32'(o_ready), 32'd1);
        check("bp_valid_drop", 32'(o_valid), 32'd0);
        rdy_auto = 1'b1;

        // Reset while RUN is at nibble index 2.
        send(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_ready", 32'(o_ready), 32'd1);
        check("midrst_valid", 32'(o_valid), 32'd0);
        check("midrst_sum", 32'(o_sum), 32'd0);
        check("midrst_carry", 32'(o_carry), 32'd0);
        check("midrst_ovf", 32'(o_ovf), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(16'h0001, 16'h0001, 1'b0, 1'b0);
        wait_valid();
        check("postrst_sum", 32'(o_sum), 32'h0002);
        wait_idle();

        // Randomised back-to-back traffic against the reference model.
        for (int t = 0; t < 200; t++) begin
            send(pick(), pick(), 1'($urandom), 1'($urandom));
        end
        wait_idle();

        // Single-nibble instance.
        send1(4'hF, 4'h1, 1'b0, 1'b0);
        for (int t = 0; t < 16; t++) begin
            send1(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_adder_seq_ctrl
